rr_logging_stream_merge: RTL

Parametrised N-channel successor to the fixed binary tree of two-input logging-bus packers. It accepts `NUM_CH` independent logging record streams, one per recorded interface (sda, ocl, bar1, pcim, pcis, …). Each channel is buffered in its own FIFO, and records are merged by fair round-robin onto a single tagged output stream that feeds the writeback path. Unlike the fixed tree it supports real downstream backpressure, a configurable per-channel buffer depth, and an optional drop-on-full mode with a drop counter.

---
 rtl/rr_logging_stream_merge.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rr_logging_stream_merge.sv
// N-channel logging record merger: one FIFO per channel, round-robin arbitration
// onto a single registered, tagged output stream with optional drop-on-full.
module rr_logging_stream_merge #(
  parameter int unsigned NUM_CH       = 5,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DROP_ON_FULL = 0,
  localparam int unsigned ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_id,
  output logic [NUM_CH-1:0]        fifo_full,
  output logic [31:0]              drop_cnt
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [DATA_W-1:0] mem_q [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0]     wptr_q [NUM_CH];
  logic [PW-1:0]     rptr_q [NUM_CH];
  logic [CW-1:0]     cnt_q  [NUM_CH];

  logic [NUM_CH-1:0] full, nonempty, wr, drop, pop;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]       drop_cnt_q, drop_cnt_d;

  logic              can_load, gnt_valid;
  logic [ID_W-1:0]   gnt_id;

  // Full is taken from the registered count, so a pop in the same cycle never frees a slot.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]     = (cnt_q[c] == CW'(FIFO_DEPTH));
      nonempty[c] = (cnt_q[c] != '0);
      in_ready[c] = (DROP_ON_FULL != 0) ? 1'b1 : !full[c];
      wr[c]       = in_valid[c] & in_ready[c] & !full[c];
      drop[c]     = (DROP_ON_FULL != 0) & in_valid[c] & full[c];
    end
  end

  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] idx_id;
    idx       = 0;
    idx_id    = '0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_id = ID_W'(idx);
      if (!gnt_valid && nonempty[idx_id]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx_id;
      end
    end
  end

  assign can_load = !out_valid_q || out_ready;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c] = can_load && gnt_valid && (gnt_id == ID_W'(c));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (can_load) begin
      out_valid_d = gnt_valid;
      if (gnt_valid) begin
        out_data_d = mem_q[gnt_id][rptr_q[gnt_id]];
        out_id_d   = gnt_id;
        rr_ptr_d   = (gnt_id == ID_W'(NUM_CH - 1)) ? '0 : gnt_id + ID_W'(1);
      end
    end
  end

  always_comb begin
    logic [31:0] drop_sum;
    logic [32:0] sum;
    drop_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      drop_sum = drop_sum + 32'(drop[c]);
    end
    sum        = {1'b0, drop_cnt_q} + {1'b0, drop_sum};
    drop_cnt_d = sum[32] ? '1 : sum[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr[c])  wptr_q[c] <= wptr_q[c] + PW'(1);
        if (pop[c]) rptr_q[c] <= rptr_q[c] + PW'(1);
        cnt_q[c] <= cnt_q[c] + CW'(wr[c]) - CW'(pop[c]);
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr[c]) mem_q[c][wptr_q[c]] <= in_data[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign fifo_full = full;
  assign drop_cnt  = drop_cnt_q;

endmodule
